pc_fetch: RTL

- Fetch front-end that owns the 16-bit program counter.
- Drives the synchronous-read instruction ROM and captures returned words into a small output buffer.
- Delivers {instr, instr_pc} over a valid/ready handshake to the downstream instruction Register / decode stage.
- Handles jump redirects by squashing in-flight and buffered fetches.

---
 rtl/pc_fetch_pkg.sv | 13 +
 rtl/pc_fetch_if.sv | 22 ++
 rtl/pc_fetch_fifo.sv | 80 ++++++++
 rtl/pc_fetch.sv | 88 ++++++++
 4 files changed

// File: rtl/pc_fetch_pkg.sv
// Shared widths, reset address and the buffered fetch-entry layout for the fetch front-end.
package pc_fetch_pkg;

  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 2;
  localparam logic [WORD_W-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch bus: ROM request/response plus the instruction valid/ready handshake to decode.
interface pc_fetch_if #(
  parameter int WIDTH = 16
);
  logic             rom_en;
  logic [WIDTH-1:0] rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic [WIDTH-1:0] instr;
  logic [WIDTH-1:0] instr_pc;
  logic             instr_valid;
  logic             instr_ready;

  modport master (
    output rom_en, rom_addr, instr, instr_pc, instr_valid,
    input  rom_data, instr_ready
  );

  modport slave (
    input  rom_en, rom_addr, instr, instr_pc, instr_valid,
    output rom_data, instr_ready
  );
endinterface

// File: rtl/pc_fetch_fifo.sv
// Small synchronous FIFO of {pc, word} entries; flush beats push and pop.
module pc_fifo
  import pc_fetch_pkg::*;
#(
  parameter int  DEPTH   = FIFO_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output entry_t           head
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pop needs data; push into a full FIFO is only accepted alongside a pop.
  assign pop_ok  = pop & (cnt_q != '0);
  assign push_ok = push & ((cnt_q != CNT_W'(DEPTH)) | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/pc_fetch.sv
// Fetch front-end: owns the pc, issues ROM reads, buffers returned words and handles redirects.
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int               WIDTH    = WORD_W,
  parameter int               DEPTH    = FIFO_DEPTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(pc_fetch_pkg::RESET_PC)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  pc_fetch_if.master       bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] word;
  } entry_t;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occupancy;
  entry_t           head;
  entry_t           push_data;
  logic             pop;
  logic             issue;

  assign pop = bus.instr_valid & bus.instr_ready;

  // The in-flight word already owns a buffer slot, so a full buffer never drops a ROM return.
  assign occupancy = OCC_W'(count) + OCC_W'(inflight_q);
  assign issue     = rst_n & ~jump & (occupancy < (OCC_W'(DEPTH) + OCC_W'(pop)));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (jump) begin
      pc_d = jump_addr;
    end else if (issue) begin
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
      pc_d          = pc_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  assign push_data.pc   = inflight_pc_q;
  assign push_data.word = bus.rom_data;

  pc_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (jump),
    .push      (inflight_q & ~jump),
    .push_data (push_data),
    .pop       (pop & ~jump),
    .count     (count),
    .head      (head)
  );

  assign bus.rom_en      = issue;
  assign bus.rom_addr    = pc_q;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = head.word;
  assign bus.instr_pc    = head.pc;

endmodule
